// File: rtl/dual_buffer_pkg.sv
// Shared constants and types for the ping-pong ADC capture buffer.
// Status word layout and capture FSM encoding live here.
package dual_buffer_pkg;

  localparam int BUF_SIZE = 1024;
  localparam logic [15:0] READ_STATE_ADDR = 16'h4000;

  localparam int ST_HAS_SWITCHED = 0;
  localparam int ST_REG_READ     = 1;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FULL
  } cap_state_e;

  function automatic logic [15:0] status_word(
    input logic reg_read,
    input logic has_switched
  );
    logic [15:0] w;
    w = '0;
    w[ST_REG_READ]     = reg_read;
    w[ST_HAS_SWITCHED] = has_switched;
    return w;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for a level from outside the clk domain,
// with single-cycle rise and fall pulses on the synchronized level.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (rst) sh <= '0;
    else     sh <= {sh[1:0], d};
  end

  assign rise = sh[1] & ~sh[2];
  assign fall = ~sh[1] & sh[2];

endmodule

// File: rtl/dual_adc_buffer.sv
// Ping-pong ADC capture buffer: one RAM fills while the other is
// held for the host bus; status at READ_STATE_ADDR locks the read side.
module dual_adc_buffer #(
  parameter int DATA_WIDTH = 12,
  parameter int BUF_SIZE   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adc_clk,
  input  logic [DATA_WIDTH-1:0] sync_adc_data,
  input  logic                  stable,
  input  logic                  sync_signal_in,
  input  logic                  en,
  input  logic                  state,
  input  logic [15:0]           rd_data,
  output logic [15:0]           wr_data
);
  import dual_buffer_pkg::*;

  localparam int AW = $clog2(BUF_SIZE);
  localparam int PW = AW + 1;

  logic adc_rise, en_rise, en_fall;

  edge_sync u_adc_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (adc_clk),
    .rise (adc_rise),
    .fall ()
  );

  edge_sync u_en_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (en),
    .rise (en_rise),
    .fall (en_fall)
  );

  logic [15:0] rd_d1, rd_d2;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        wbit;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_d1    <= '0;
      rd_d2    <= '0;
      bus_addr <= '0;
      bus_rd   <= 1'b0;
      wbit     <= 1'b0;
    end else begin
      rd_d1 <= rd_data;
      rd_d2 <= rd_d1;
      if (en_rise) begin
        bus_addr <= rd_d2;
        bus_rd   <= state;
      end
      // on the fall cycle rd_d2 is already past the data phase
      if (!en_fall) wbit <= rd_d2[0];
    end
  end

  logic lock_set, lock_clr, st_wr;
  logic reg_read, has_switched, swap;
  logic write_buf;
  logic [PW-1:0] write_ptr;
  cap_state_e cap_st;

  assign st_wr    = en_fall && !bus_rd && bus_addr == READ_STATE_ADDR;
  assign lock_set = st_wr && wbit;
  assign lock_clr = st_wr && !wbit;
  assign swap     = cap_st == FULL && !reg_read && !lock_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_read     <= 1'b0;
      has_switched <= 1'b0;
    end else if (lock_set) begin
      reg_read     <= 1'b1;
      has_switched <= 1'b0;
    end else begin
      if (lock_clr) reg_read <= 1'b0;
      if (swap) has_switched <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_st    <= IDLE;
      write_ptr <= '0;
      write_buf <= 1'b0;
    end else begin
      unique case (cap_st)
        IDLE: begin
          if (adc_rise && stable && sync_signal_in) begin
            write_ptr <= PW'(1);
            cap_st    <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!stable) begin
            write_ptr <= '0;
            cap_st    <= IDLE;
          end else if (adc_rise) begin
            write_ptr <= write_ptr + 1'b1;
            if (write_ptr == PW'(BUF_SIZE - 1)) cap_st <= FULL;
          end
        end
        FULL: begin
          if (swap) begin
            write_buf <= ~write_buf;
            write_ptr <= '0;
            cap_st    <= IDLE;
          end
        end
        default: cap_st <= IDLE;
      endcase
    end
  end

  logic          mem_we;
  logic [AW-1:0] waddr;

  always_comb begin
    mem_we = 1'b0;
    waddr  = write_ptr[AW-1:0];
    unique case (cap_st)
      IDLE: begin
        mem_we = adc_rise && stable && sync_signal_in;
        waddr  = '0;
      end
      CAPTURE: mem_we = adc_rise && stable;
      default: mem_we = 1'b0;
    endcase
  end

  logic [DATA_WIDTH-1:0] mem0 [BUF_SIZE];
  logic [DATA_WIDTH-1:0] mem1 [BUF_SIZE];
  logic [DATA_WIDTH-1:0] rd_q0, rd_q1;

  always_ff @(posedge clk) begin
    if (mem_we && !write_buf) mem0[waddr] <= sync_adc_data;
    if (en_rise) rd_q0 <= mem0[rd_d2[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (mem_we && write_buf) mem1[waddr] <= sync_adc_data;
    if (en_rise) rd_q1 <= mem1[rd_d2[AW-1:0]];
  end

  logic rd_go, rd_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_go   <= 1'b0;
      rd_sel  <= 1'b0;
      wr_data <= '0;
    end else begin
      rd_go  <= en_rise && state;
      rd_sel <= ~write_buf;
      if (rd_go) begin
        if (bus_addr == READ_STATE_ADDR)
          wr_data <= status_word(reg_read, has_switched);
        else if (bus_addr < 16'(BUF_SIZE))
          wr_data <= rd_sel ? 16'(rd_q1) : 16'(rd_q0);
        else
          wr_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dual_adc_buffer.sv
// Directed bench for dual_adc_buffer: fills, host lock/unlock,
// aborts, address decode and mid-capture reset.
module tb_dual_adc_buffer;
  import dual_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        adc_clk;
  logic [11:0] sync_adc_data;
  logic        stable;
  logic        sync_signal_in;
  logic        en;
  logic        state;
  logic [15:0] rd_data;
  logic [15:0] wr_data;

  int n_chk  = 0;
  int n_fail = 0;
  int sp [6] = '{0, 1, 2, 511, 1022, 1023};

  always #5 clk = ~clk;

  dual_adc_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .adc_clk        (adc_clk),
    .sync_adc_data  (sync_adc_data),
    .stable         (stable),
    .sync_signal_in (sync_signal_in),
    .en             (en),
    .state          (state),
    .rd_data        (rd_data),
    .wr_data        (wr_data)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic adc_sample(input logic [11:0] v);
    sync_adc_data = v;
    adc_clk = 1'b1;
    tick(3);
    adc_clk = 1'b0;
    tick(3);
  endtask

  task automatic fill(input int base, input int n);
    for (int i = 0; i < n; i++) adc_sample(12'(base + i));
    tick(2);
  endtask

  task automatic host_read(input logic [15:0] a, output logic [15:0] d);
    state   = 1'b1;
    rd_data = a;
    en      = 1'b1;
    tick(4);
    d  = wr_data;
    en = 1'b0;
    tick(3);
  endtask

  task automatic host_write(input logic [15:0] a, input logic [15:0] d);
    state   = 1'b0;
    rd_data = a;
    en      = 1'b1;
    tick(3);
    rd_data = d;
    tick(3);
    en = 1'b0;
    tick(4);
  endtask

  task automatic test_reset;
    logic [15:0] d;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    n_chk++;
    if (wr_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_wr_data: got %h expected 0000", wr_data);
    end
    n_chk++;
    if ({dut.write_buf, dut.write_ptr} !== 12'h0 || dut.cap_st !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got wb=%b ptr=%0d st=%0d expected 0 0 0",
               dut.write_buf, dut.write_ptr, dut.cap_st);
    end
    host_read(READ_STATE_ADDR, d);
    n_chk++;
    if (d !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_status: got %h expected 0000", d);
    end
  endtask

  task automatic test_fill_and_lock;
    logic [15:0] d;
    fill(10, 1024);
    host_read(READ_STATE_ADDR, d);
    n_chk++;
    if (d !== 16'h0001) begin
      n_fail++;
      $display("FAIL fill1_status: got %h expected 0001", d);
    end
    n_chk++;
    if (dut.write_buf !== 1'b1) begin
      n_fail++;
      $display("FAIL fill1_wb: got %b expected 1", dut.write_buf);
    end
    host_write(READ_STATE_ADDR, 16'h0001);
    host_read(READ_STATE_ADDR, d);
    n_chk++;
    if (d !== 16'h0002) begin
      n_fail++;
      $display("FAIL lock_status: got %h expected 0002", d);
    end
    for (int i = 0; i < 1024; i++) begin
      host_read(16'(i), d);
      n_chk++;
      if (d !== 16'(i + 10)) begin
        n_fail++;
        $display("FAIL full_read[%0d]: got %h expected %h", i, d, 16'(i + 10));
      end
    end
  endtask

  task automatic test_locked_swap;
    logic [15:0] d;
    fill(20, 1024);
    host_read(READ_STATE_ADDR, d);
    n_chk++;
    if (d !== 16'h0002) begin
      n_fail++;
      $display("FAIL locked_status: got %h expected 0002", d);
    end
    n_chk++;
    if (dut.write_buf !== 1'b1 || dut.cap_st !== FULL) begin
      n_fail++;
      $display("FAIL locked_hold: got wb=%b st=%0d expected 1 2",
               dut.write_buf, dut.cap_st);
    end
    foreach (sp[k]) begin
      host_read(16'(sp[k]), d);
      n_chk++;
      if (d !== 16'(sp[k] + 10)) begin
        n_fail++;
        $display("FAIL locked_read[%0d]: got %h expected %h",
                 sp[k], d, 16'(sp[k] + 10));
      end
    end
    host_write(READ_STATE_ADDR, 16'h0000);
    host_read(READ_STATE_ADDR, d);
    n_chk++;
    if (d !== 16'h0001) begin
      n_fail++;
      $display("FAIL unlock_status: got %h expected 0001", d);
    end
    n_chk++;
    if (dut.write_buf !== 1'b0) begin
      n_fail++;
      $display("FAIL unlock_wb: got %b expected 0", dut.write_buf);
    end
    foreach (sp[k]) begin
      host_read(16'(sp[k]), d);
      n_chk++;
      if (d !== 16'(sp[k] + 20)) begin
        n_fail++;
        $display("FAIL unlock_read[%0d]: got %h expected %h",
                 sp[k], d, 16'(sp[k] + 20));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    int offs [3] = '{10, 20, 30};
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (dut.write_buf !== 1'(k % 2)) begin
        n_fail++;
        $display("FAIL b2b_wb[%0d]: got %b expected %b",
                 k, dut.write_buf, 1'(k % 2));
      end
      fill(offs[k], 1024);
      host_read(READ_STATE_ADDR, d);
      n_chk++;
      if (d !== 16'h0001) begin
        n_fail++;
        $display("FAIL b2b_status[%0d]: got %h expected 0001", k, d);
      end
      host_write(READ_STATE_ADDR, 16'h0001);
      foreach (sp[j]) begin
        host_read(16'(sp[j]), d);
        n_chk++;
        if (d !== 16'(sp[j] + offs[k])) begin
          n_fail++;
          $display("FAIL b2b_read[%0d][%0d]: got %h expected %h",
                   k, sp[j], d, 16'(sp[j] + offs[k]));
        end
      end
      host_write(READ_STATE_ADDR, 16'h0000);
    end
  endtask

  task automatic test_abort;
    logic [15:0] d;
    fill(900, 500);
    stable = 1'b0;
    tick(3);
    n_chk++;
    if (dut.write_ptr !== 11'd0 || dut.cap_st !== IDLE || dut.write_buf !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_state: got ptr=%0d st=%0d wb=%b expected 0 0 1",
               dut.write_ptr, dut.cap_st, dut.write_buf);
    end
    host_read(READ_STATE_ADDR, d);
    n_chk++;
    if (d !== 16'h0000) begin
      n_fail++;
      $display("FAIL abort_status: got %h expected 0000", d);
    end
    stable = 1'b1;
    tick(2);
    fill(40, 1024);
    host_read(READ_STATE_ADDR, d);
    n_chk++;
    if (d !== 16'h0001 || dut.write_buf !== 1'b0) begin
      n_fail++;
      $display("FAIL refill_status: got %h wb=%b expected 0001 0",
               d, dut.write_buf);
    end
    foreach (sp[k]) begin
      host_read(16'(sp[k]), d);
      n_chk++;
      if (d !== 16'(sp[k] + 40)) begin
        n_fail++;
        $display("FAIL refill_read[%0d]: got %h expected %h",
                 sp[k], d, 16'(sp[k] + 40));
      end
    end
  endtask

  task automatic test_addr_decode;
    logic [15:0] d;
    host_read(16'h2000, d);
    n_chk++;
    if (d !== 16'h0000) begin
      n_fail++;
      $display("FAIL read_2000: got %h expected 0000", d);
    end
    host_read(16'h0400, d);
    n_chk++;
    if (d !== 16'h0000) begin
      n_fail++;
      $display("FAIL read_0400: got %h expected 0000", d);
    end
    host_write(16'h0005, 16'hBEEF);
    host_read(16'h0005, d);
    n_chk++;
    if (d !== 16'd45) begin
      n_fail++;
      $display("FAIL ignored_write: got %h expected %h", d, 16'd45);
    end
    host_read(READ_STATE_ADDR, d);
    n_chk++;
    if (d !== 16'h0001) begin
      n_fail++;
      $display("FAIL ignored_status: got %h expected 0001", d);
    end
  endtask

  task automatic test_reset_mid_capture;
    logic [15:0] d;
    fill(70, 300);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    n_chk++;
    if (wr_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL midrst_wr_data: got %h expected 0000", wr_data);
    end
    n_chk++;
    if ({dut.write_buf, dut.write_ptr} !== 12'h0 || dut.cap_st !== IDLE) begin
      n_fail++;
      $display("FAIL midrst_state: got wb=%b ptr=%0d st=%0d expected 0 0 0",
               dut.write_buf, dut.write_ptr, dut.cap_st);
    end
    host_read(READ_STATE_ADDR, d);
    n_chk++;
    if (d !== 16'h0000) begin
      n_fail++;
      $display("FAIL midrst_status: got %h expected 0000", d);
    end
  endtask

  initial begin
    rst            = 1'b1;
    adc_clk        = 1'b0;
    sync_adc_data  = '0;
    stable         = 1'b1;
    sync_signal_in = 1'b1;
    en             = 1'b0;
    state          = 1'b1;
    rd_data        = '0;
    test_reset();
    test_fill_and_lock();
    test_locked_swap();
    test_back_to_back();
    test_abort();
    test_addr_decode();
    test_reset_mid_capture();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
